// File: rtl/step_pkg.sv
// Shared definitions for the single-step clock generator: FSM state encoding
// and the base debounce/step counter width.
package step_pkg;

   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRESS_DB = 3'd1,
      HIGH     = 3'd2,
      WAIT_REL = 3'd3,
      REL_DB   = 3'd4
   } state_t;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for asynchronous board switches and buttons;
// asynchronous active-high reset clears both stages.
module btn_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;

endmodule

// File: rtl/step_clock_gen.sv
// Debounced single-step clock generator for the pipeline CPU.
// Optional auto-repeat while the button is held: define STEP_AUTOREPEAT_EN.
module step_clock_gen
   import step_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 5000,
   parameter int unsigned HIGH_CYCLES     = 16,
   parameter int unsigned REPEAT_CYCLES   = 2000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       button,
   input  logic       enable,
   output logic       step_clk,
   output logic       step_pulse,
   output logic [7:0] step_count,
   output logic       busy
);

`ifdef STEP_AUTOREPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   // Counter widens only when the repeat interval cannot fit in CNT_W bits.
   localparam int unsigned W = (AUTO && (REPEAT_CYCLES > (1 << CNT_W))) ?
                               $clog2(REPEAT_CYCLES) : CNT_W;

   localparam logic [W-1:0] DB_LAST = W'(DEBOUNCE_CYCLES - 1);
   localparam logic [W-1:0] HI_LAST = W'(HIGH_CYCLES - 1);
`ifdef STEP_AUTOREPEAT_EN
   localparam logic [W-1:0] RP_LAST = W'(REPEAT_CYCLES - 1);
`endif

   logic         w_btn_s;
   state_t       r_state;
   state_t       w_state_nxt;
   logic [W-1:0] r_cnt;
   logic [W-1:0] w_cnt_nxt;
   logic         r_blocked;
   logic         w_block_nxt;
   logic         w_step_start;
   logic         r_step_clk;
   logic         r_step_pulse;
   logic [7:0]   r_step_count;
   logic         r_busy;

   btn_sync u_sync (
      .i_clk (clk),
      .i_rst (reset),
      .i_d   (button),
      .o_q   (w_btn_s)
   );

   // A press seen while disabled stays blocked until the button is released,
   // so raising enable mid-hold cannot produce a step without a fresh press.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + W'(1);
      w_block_nxt = r_blocked;
      case (r_state)
         IDLE: begin
            w_cnt_nxt = r_cnt;
            if (!w_btn_s)        w_block_nxt = 1'b0;
            else if (!enable)    w_block_nxt = 1'b1;
            else if (!r_blocked) w_state_nxt = PRESS_DB;
         end
         PRESS_DB: begin
            if (!w_btn_s)              w_state_nxt = IDLE;
            else if (r_cnt == DB_LAST) w_state_nxt = HIGH;
         end
         HIGH: begin
            if (r_cnt == HI_LAST) w_state_nxt = WAIT_REL;
         end
         WAIT_REL: begin
            w_cnt_nxt = r_cnt;
            if (!w_btn_s)              w_state_nxt = REL_DB;
`ifdef STEP_AUTOREPEAT_EN
            else if (r_cnt != RP_LAST) w_cnt_nxt = r_cnt + W'(1);
            else if (enable)           w_state_nxt = HIGH;
`endif
         end
         REL_DB: begin
            if (w_btn_s)               w_state_nxt = WAIT_REL;
            else if (r_cnt == DB_LAST) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_state_nxt != r_state) w_cnt_nxt = '0;
   end

   assign w_step_start = (w_state_nxt == HIGH) && (r_state != HIGH);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_blocked    <= 1'b0;
         r_step_clk   <= 1'b0;
         r_step_pulse <= 1'b0;
         r_step_count <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_blocked    <= w_block_nxt;
         r_step_clk   <= (w_state_nxt == HIGH);
         r_step_pulse <= w_step_start;
         r_busy       <= (w_state_nxt != IDLE);
         if (w_step_start) r_step_count <= r_step_count + 8'd1;
      end
   end

   assign step_clk   = r_step_clk;
   assign step_pulse = r_step_pulse;
   assign step_count = r_step_count;
   assign busy       = r_busy;

endmodule

// File: tb/tb_step_clock_gen.sv
// Randomized press/bounce/release episodes; expected step times and counts
// are queued by the stimulus and checked by an independent pulse monitor.
module tb_step_clock_gen;

   localparam int unsigned D  = 4;
   localparam int unsigned HC = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       button;
   logic       enable;
   logic       step_clk;
   logic       step_pulse;
   logic [7:0] step_count;
   logic       busy;

   step_clock_gen #(.DEBOUNCE_CYCLES(D), .HIGH_CYCLES(HC)) dut (
      .clk        (clk),
      .reset      (reset),
      .button     (button),
      .enable     (enable),
      .step_clk   (step_clk),
      .step_pulse (step_pulse),
      .step_count (step_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   typedef struct {
      int t;
      int cnt;
   } exp_t;

   exp_t q[$];
   int   tests       = 0;
   int   fails       = 0;
   int   exp_steps   = 0;
   int   pulses_seen = 0;
   bit   mon_on      = 1'b0;

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
      end
   endtask

   // Monitor: pops one expectation per observed step pulse.
   initial begin
      int   run;
      exp_t e;
      run = 0;
      forever begin
         @(posedge clk);
         #2;
         if (mon_on) begin
            if (step_pulse) begin
               pulses_seen++;
               if (q.size() == 0) begin
                  check("unexpected_pulse", edge_n, -1);
               end else begin
                  e = q.pop_front();
                  check("pulse_time", edge_n, e.t);
                  check("pulse_count", int'(step_count), e.cnt);
               end
            end else if (q.size() != 0 && q[0].t < edge_n) begin
               e = q.pop_front();
               check("missed_pulse", -1, e.t);
            end
            if (step_clk) run++;
            else if (run != 0) begin
               check("high_width", run, HC);
               run = 0;
            end
         end else begin
            run = 0;
         end
      end
   end

   task automatic drive(input logic b, input int n);
      repeat (n) begin
         @(negedge clk);
         button = b;
      end
   endtask

   // One press episode starting from a settled idle state.
   task automatic episode(input bit en, input bit en_mid);
      int e0;
      int h;
      check("idle_busy", int'(busy), 0);
      @(negedge clk);
      enable = en;
      button = 1'b0;
      repeat ($urandom_range(0, 3)) begin
         drive(1'b1, int'($urandom_range(1, D)));
         drive(1'b0, int'($urandom_range(1, 3)));
      end
      h = D + 1 + HC + int'($urandom_range(0, 6));
      @(negedge clk);
      button = 1'b1;
      e0 = edge_n + 1;
      if (en) begin
         exp_steps++;
         q.push_back('{e0 + D + 2, exp_steps % 256});
      end
      for (int i = 1; i < h; i++) begin
         @(negedge clk);
         if (en_mid && i == h / 2) enable = 1'b1;
         button = 1'b1;
      end
      repeat ($urandom_range(0, 3)) begin
         drive(1'b0, int'($urandom_range(1, D)));
         drive(1'b1, int'($urandom_range(1, 3)));
      end
      drive(1'b0, D + 4 + int'($urandom_range(0, 3)));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int r;
      int k;
      int e0;
      reset  = 1'b1;
      button = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_step_clk", int'(step_clk), 0);
      check("rst_step_pulse", int'(step_pulse), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_step_count", int'(step_count), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      mon_on = 1'b1;

      episode(1'b1, 1'b0);
      episode(1'b0, 1'b0);
      episode(1'b0, 1'b1);
      episode(1'b1, 1'b0);

      n = 0;
      while (exp_steps < 260 && n < 400) begin
         r = int'($urandom_range(0, 7));
         episode(r > 1, r == 1);
         n++;
      end
      repeat (10) @(negedge clk);
      check("queue_drained", q.size(), 0);
      check("pulse_total", pulses_seen, exp_steps);
      check("final_count", int'(step_count), exp_steps % 256);

      // Reset in the middle of a step, with the button held through it.
      @(negedge clk);
      enable = 1'b1;
      button = 1'b1;
      e0 = edge_n + 1;
      exp_steps++;
      q.push_back('{e0 + D + 2, exp_steps % 256});
      k = 0;
      while (!step_clk && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("reach_high", int'(step_clk), 1);
      @(negedge clk);
      mon_on = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("rst_mid_step_clk", int'(step_clk), 0);
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_count", int'(step_count), 0);
      q.delete();
      @(negedge clk);
      reset = 1'b0;
      mon_on = 1'b1;
      e0 = edge_n + 1;
      exp_steps = 1;
      q.push_back('{e0 + D + 2, 1});
      drive(1'b1, D + HC + 8);
      drive(1'b0, D + 6);
      check("post_rst_drained", q.size(), 0);
      check("post_rst_count", int'(step_count), 1);
      check("post_rst_busy", int'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/step_clock_gen.md
Name: step_clock_gen

Overview:
- Front-end stage that turns the raw single-step push-button into a clean, debounced single-step clock for the pipeline CPU.
- Drives the CPU `clock` input (step_clk), supplies a one-cycle step strobe for memory/display logic, and keeps an 8-bit step counter for the seven-segment display.
- Replaces the free-running counter currently wrapped around the button.
- Sits between board pins and the CPU in the top level; all logic is in the board `clk` domain.

Parameters:
- DEBOUNCE_CYCLES, 5000, clk cycles the synchronized button must stay stable (press and release) before it is accepted; legal range 2..65535.
- HIGH_CYCLES, 16, clk cycles step_clk is held high per step; legal range 1..65535.
- REPEAT_CYCLES, 2000000, hold time before auto-repeat starts, and the period between repeats; used only with AUTOREPEAT_EN.

Ports:
- clk  in  1  board clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- button  in  1  raw, asynchronous, bouncing push-button level.
- enable  in  1  when 0, new presses are ignored; a step already accepted still completes.
- step_clk  out  1  stretched step clock to CPU `clock`; high only in state HIGH.
- step_pulse  out  1  one-clk strobe in the first cycle of each step_clk high phase.
- step_count  out  8  number of steps issued, mod 256.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, synchronizer flops=0, counter=0, step_clk=0, step_pulse=0, step_count=0, busy=0. Asserting reset during HIGH drops step_clk in the same instant.
- Synchronizer: button passes through 2 flops to give btn_s. FSM uses btn_s only.
- Counter: one 16-bit counter `cnt`, cleared on every state change.
- IDLE: if btn_s=1 and enable=1, go to PRESS_DB.
- PRESS_DB:
  - If btn_s=0, go to IDLE (bounce rejected, no step).
  - Else if cnt==DEBOUNCE_CYCLES-1, go to HIGH.
  - Else cnt+1.
- HIGH:
  - step_clk=1 throughout; step_pulse=1 in the first HIGH cycle only; step_count+1 in that same cycle (wraps 255 to 0).
  - When cnt==HIGH_CYCLES-1, go to WAIT_REL.
  - Button level is ignored in HIGH.
- WAIT_REL: if btn_s=0, go to REL_DB.
- REL_DB:
  - If btn_s=1, go to WAIT_REL (release bounce).
  - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE.
- Latency: edge 0 is the first rising clk edge that samples button=1. step_clk rises at edge DEBOUNCE_CYCLES+2 if button stays high.
- Outputs are registered from state; no combinational path from button to any output.
- enable=0 blocks only the IDLE to PRESS_DB transition.
- Held button gives exactly one step; another step requires a debounced release followed by a new press.

Optional Feature:
- Macro: STEP_AUTOREPEAT_EN.
- Defined: in WAIT_REL, cnt counts while btn_s=1. When cnt reaches REPEAT_CYCLES-1 and enable=1, go to HIGH (new step) and clear cnt. Repeats continue every HIGH_CYCLES+REPEAT_CYCLES cycles while the button is held.
- Undefined: WAIT_REL only waits for release, and REPEAT_CYCLES is unused.

Decomposition:
- Package step_pkg: state encoding (IDLE, PRESS_DB, HIGH, WAIT_REL, REL_DB as 3-bit constants) and CNT_W=16.
- Sub-module btn_sync: 2-flop synchronizer with async active-high reset to 0. It is reused for the reset/enable switches elsewhere in the top level.

Test Plan (DEBOUNCE_CYCLES=4, HIGH_CYCLES=3):
- Clean press: button 0 to 1 at edge 0, held 40 cycles -> step_clk high at edges 6..8; step_pulse high only at edge 6; step_count 0 to 1; no further steps while held.
- Bounce: button toggles 1,0,1,0 with 2-cycle spacing, then stays 0 -> no step_clk, step_count stays 0, FSM returns to IDLE.
- Release bounce: after a step, release with a 1-cycle glitch back to 1, then a clean release and press -> exactly 2 total steps; step_count=2.
- Wrap: 256 clean presses -> step_count returns to 0; step_pulse count = 256.
- enable=0 during press -> no step. enable=1 set mid-hold -> step only after release and a fresh press.
- Reset asserted mid-HIGH -> step_clk, busy and step_count go to 0 immediately. After reset deasserts with button still held, a new step is issued after debounce. With STEP_AUTOREPEAT_EN and REPEAT_CYCLES=10, a 60-cycle hold -> 1 + repeat steps every 13 cycles.
